// File: rtl/vec_stream_pkg.sv
// Shared types and constants for the vec_stream_io streaming front/back end.
// Optional framing support is enabled by defining VEC_STREAM_LAST_EN.
package vec_stream_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    SEND    = 2'd2
  } vs_state_e;

  localparam int VS_MAX_LAT = 15;

  // Counter width for a dimension, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_stream_io_if.sv
// Valid/ready element stream with a frame marker; used for both the input
// and output side of vec_stream_io.
interface vec_stream_io_if #(
  parameter int WIDTH = 16
);

  logic                    valid;
  logic                    ready;
  logic                    last;
  logic signed [WIDTH-1:0] data;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/vec_serializer.sv
// Output buffer for one core result; streams its OUT_DIM elements out one per
// handshake. m_last is driven only when VEC_STREAM_LAST_EN is defined.
module vec_serializer
  import vec_stream_pkg::*;
#(
  parameter int OUT_DIM = 2,
  parameter int WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic [OUT_DIM*WIDTH-1:0] i_vec,
  vec_stream_io_if.master          m_if,
  output logic                     o_done
);

  localparam int OUT_IW = cntWidth(OUT_DIM);

  logic [OUT_DIM-1:0][WIDTH-1:0] r_buf;
  logic [OUT_IW-1:0]             r_outIdx;
  logic                          r_valid;

  logic w_hs;
  logic w_lastIdx;

  assign w_hs      = r_valid & m_if.ready;
  assign w_lastIdx = (r_outIdx == OUT_IW'(OUT_DIM - 1));

  // A load always wins: the top only loads while no element is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf    <= '0;
      r_outIdx <= '0;
      r_valid  <= 1'b0;
    end else if (i_load) begin
      r_buf    <= i_vec;
      r_outIdx <= '0;
      r_valid  <= 1'b1;
    end else if (w_hs) begin
      if (w_lastIdx) begin
        r_outIdx <= '0;
        r_valid  <= 1'b0;
      end else begin
        r_outIdx <= r_outIdx + 1'b1;
      end
    end
  end

  assign m_if.valid = r_valid;
  assign m_if.data  = r_buf[r_outIdx];
  assign o_done     = w_hs & w_lastIdx;

`ifdef VEC_STREAM_LAST_EN
  assign m_if.last = r_valid & w_lastIdx;
`else
  assign m_if.last = 1'b0;
`endif

endmodule

// File: rtl/vec_stream_io.sv
// Packs IN_DIM streamed elements into core_in, waits CORE_LAT cycles, then
// streams the core result back out. Framing checks need VEC_STREAM_LAST_EN.
module vec_stream_io
  import vec_stream_pkg::*;
#(
  parameter int IN_DIM   = 10,
  parameter int OUT_DIM  = 2,
  parameter int WIDTH    = 16,
  parameter int CORE_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  vec_stream_io_if.slave           s_if,
  vec_stream_io_if.master          m_if,
  output logic [IN_DIM*WIDTH-1:0]  core_in,
  input  logic [OUT_DIM*WIDTH-1:0] core_out,
  output logic                     busy,
  output logic                     frame_err
);

  localparam int IN_IW = cntWidth(IN_DIM);
  localparam int LAT_W = cntWidth(VS_MAX_LAT + 1);

  vs_state_e                    r_state;
  logic [IN_IW-1:0]             r_inIdx;
  logic [LAT_W-1:0]             r_latCnt;
  logic [IN_DIM-1:0][WIDTH-1:0] r_coreIn;

  logic w_sHs;
  logic w_inLast;
  logic w_frameBad;
  logic w_capture;
  logic w_sendDone;

  assign s_if.ready = (r_state == LOAD) & ~rst;
  assign w_sHs      = s_if.valid & s_if.ready;
  assign w_inLast   = (r_inIdx == IN_IW'(IN_DIM - 1));
  assign w_capture  = (r_state == COMPUTE) && (r_latCnt == '0);

  assign core_in = r_coreIn;
  assign busy    = (r_state != LOAD);

`ifdef VEC_STREAM_LAST_EN
  logic r_frameErr;

  // A frame marker on the wrong slot, or missing on the final slot, drops the frame.
  assign w_frameBad = w_sHs & (s_if.last != w_inLast);

  always_ff @(posedge clk) begin
    if (rst) r_frameErr <= 1'b0;
    else     r_frameErr <= w_frameBad;
  end

  assign frame_err = r_frameErr;
`else
  assign w_frameBad = 1'b0;
  assign frame_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= LOAD;
      r_inIdx  <= '0;
      r_latCnt <= '0;
      r_coreIn <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_sHs) begin
            r_coreIn[r_inIdx] <= s_if.data;
            if (w_frameBad) begin
              r_inIdx <= '0;
            end else if (w_inLast) begin
              r_inIdx  <= '0;
              r_latCnt <= LAT_W'(CORE_LAT - 1);
              r_state  <= COMPUTE;
            end else begin
              r_inIdx <= r_inIdx + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (r_latCnt == '0) r_state  <= SEND;
          else                r_latCnt <= r_latCnt - 1'b1;
        end
        SEND: begin
          if (w_sendDone) r_state <= LOAD;
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  vec_serializer #(
    .OUT_DIM (OUT_DIM),
    .WIDTH   (WIDTH)
  ) u_serializer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_capture),
    .i_vec  (core_out),
    .m_if   (m_if),
    .o_done (w_sendDone)
  );

endmodule

// File: tb/tb_vec_stream_io.sv
// Self-checking bench for vec_stream_io: a frame-level model checks dutA every
// cycle, directed literals pin the model; dutB covers CORE_LAT=3.
module tb_vec_stream_io;

  localparam int IN_DIM  = 10;
  localparam int OUT_DIM = 2;
  localparam int WIDTH   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  vec_stream_io_if #(.WIDTH(WIDTH)) sA ();
  vec_stream_io_if #(.WIDTH(WIDTH)) mA ();
  vec_stream_io_if #(.WIDTH(WIDTH)) sB ();
  vec_stream_io_if #(.WIDTH(WIDTH)) mB ();

  logic [IN_DIM*WIDTH-1:0]  coreInA, coreInB;
  logic [OUT_DIM*WIDTH-1:0] coreOutA, coreOutB;
  logic busyA, busyB, errA, errB;

  // Combinational core stand-in: out0 = in0 + in1, out1 = in9.
  assign coreOutA = {coreInA[9*WIDTH +: WIDTH], coreInA[0 +: WIDTH] + coreInA[WIDTH +: WIDTH]};
  assign coreOutB = {coreInB[9*WIDTH +: WIDTH], coreInB[0 +: WIDTH] + coreInB[WIDTH +: WIDTH]};

  vec_stream_io #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .WIDTH(WIDTH), .CORE_LAT(1)) dutA (
    .clk(clk), .rst(rst), .s_if(sA), .m_if(mA),
    .core_in(coreInA), .core_out(coreOutA), .busy(busyA), .frame_err(errA)
  );

  vec_stream_io #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .WIDTH(WIDTH), .CORE_LAT(3)) dutB (
    .clk(clk), .rst(rst), .s_if(sB), .m_if(mB),
    .core_in(coreInB), .core_out(coreOutB), .busy(busyB), .frame_err(errB)
  );

  task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Frame-level model of dutA: collects accepted inputs, queues the two results
  // once a frame completes, and checks every observable output each cycle.
  logic [15:0] frame [IN_DIM];
  logic [15:0] expQ [$];
  int inCnt = 0;
  bit pending = 0;
  bit errNext = 0;

  always @(negedge clk) begin
    bit bad;
    bad = 1'b0;
    if (rst) begin
      inCnt = 0;
      expQ.delete();
      pending = 0;
      errNext = 0;
    end else begin
      checkOutput("model s_ready", sA.ready, !pending);
      checkOutput("model busy", busyA, pending);
      checkOutput("model frame_err", errA, errNext);
      if (mA.valid) begin
        if (expQ.size() == 0) begin
          checkOutput("model unexpected m_valid", mA.valid, 0);
        end else begin
          checkOutput("model m_data", mA.data, expQ[0]);
`ifdef VEC_STREAM_LAST_EN
          checkOutput("model m_last", mA.last, expQ.size() == 1);
`else
          checkOutput("model m_last", mA.last, 0);
`endif
          if (mA.ready) begin
            void'(expQ.pop_front());
            if (expQ.size() == 0) pending = 0;
          end
        end
      end else begin
        checkOutput("model m_last idle", mA.last, 0);
      end
      if (sA.valid && sA.ready) begin
        frame[inCnt] = sA.data;
        inCnt++;
`ifdef VEC_STREAM_LAST_EN
        bad = (sA.last != (inCnt == IN_DIM));
`endif
        if (bad) begin
          inCnt = 0;
        end else if (inCnt == IN_DIM) begin
          expQ.push_back(frame[0] + frame[1]);
          expQ.push_back(frame[IN_DIM-1]);
          inCnt = 0;
          pending = 1;
        end
      end
      errNext = bad;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one element and hold it until accepted; returns just after the accepting edge.
  task automatic applyStimulus(input int sel, input logic [15:0] data, input logic last);
    int n;
    logic rdy;
    n = 0;
    if (sel == 0) begin sA.valid = 1'b1; sA.data = data; sA.last = last; end
    else          begin sB.valid = 1'b1; sB.data = data; sB.last = last; end
    do begin
      @(negedge clk);
      n++;
      rdy = (sel == 0) ? sA.ready : sB.ready;
    end while (!rdy && n < 100);
    if (!rdy) checkOutput("input handshake timeout", rdy, 1);
    tick();
  endtask

  task automatic sendFrame(input int sel, input logic [IN_DIM*16-1:0] vec, input bit gaps);
    for (int i = 0; i < IN_DIM; i++) begin
      applyStimulus(sel, vec[i*16 +: 16], (i == IN_DIM - 1));
      if (gaps && i < IN_DIM - 1) begin
        sA.valid = 1'b0;
        tick();
      end
    end
    if (sel == 0) sA.valid = 1'b0;
    else          sB.valid = 1'b0;
  endtask

  // Counts cycles from the last input handshake until m_valid is first seen.
  task automatic measureLatency(input int sel, input int expected, input string name);
    int n;
    logic v;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      v = (sel == 0) ? mA.valid : mB.valid;
    end while (!v && n < 20);
    checkOutput(name, n, expected);
  endtask

  task automatic waitIdle(input int sel);
    int n;
    logic v;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      v = (sel == 0) ? mA.valid : mB.valid;
    end while (v && n < 50);
    if (v) checkOutput("output drain timeout", v, 0);
    tick();
  endtask

  logic [IN_DIM*16-1:0] basicVec;
  logic [IN_DIM*16-1:0] wrapVec;
  int seenValid;

  initial begin
    for (int i = 0; i < IN_DIM; i++) begin
      basicVec[i*16 +: 16] = 16'((i + 1) << 8);
      wrapVec[i*16 +: 16]  = 16'(16'h1234 * i);
    end
    wrapVec[0*16 +: 16] = 16'h8000;
    wrapVec[1*16 +: 16] = 16'h8001;
    wrapVec[9*16 +: 16] = 16'h7FFF;

    sA.valid = 1'b0; sA.data = '0; sA.last = 1'b0; mA.ready = 1'b1;
    sB.valid = 1'b0; sB.data = '0; sB.last = 1'b0; mB.ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset s_ready A", sA.ready, 0);
    checkOutput("reset m_valid A", mA.valid, 0);
    checkOutput("reset m_data A", mA.data, 0);
    checkOutput("reset core_in A", coreInA, 0);
    checkOutput("reset busy A", busyA, 0);
    checkOutput("reset frame_err A", errA, 0);
    checkOutput("reset m_last A", mA.last, 0);
    checkOutput("reset s_ready B", sB.ready, 0);
    checkOutput("reset m_valid B", mB.valid, 0);
    tick();
    rst = 1'b0;

    $display("[TB] basic frame");
    sendFrame(0, basicVec, 0);
    measureLatency(0, 2, "first m_valid latency CORE_LAT=1");
    checkOutput("basic core_in slot0", coreInA[0 +: 16], 16'h0100);
    checkOutput("basic core_in slot9", coreInA[9*16 +: 16], 16'h0A00);
    checkOutput("basic core_in vector", coreInA, basicVec);
    checkOutput("basic m_data 0", mA.data, 16'h0300);
    @(negedge clk);
    checkOutput("basic m_data 1", mA.data, 16'h0A00);
    checkOutput("basic m_valid 1", mA.valid, 1);
    waitIdle(0);

    $display("[TB] backpressure");
    mA.ready = 1'b0;
    sendFrame(0, basicVec, 0);
    measureLatency(0, 2, "backpressure latency");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("stall m_valid", mA.valid, 1);
      checkOutput("stall m_data", mA.data, 16'h0300);
    end
    tick();
    mA.ready = 1'b1;
    @(negedge clk);
    checkOutput("release m_data 0", mA.data, 16'h0300);
    @(negedge clk);
    checkOutput("release m_data 1", mA.data, 16'h0A00);
    waitIdle(0);

    $display("[TB] input gaps");
    sendFrame(0, basicVec, 1);
    measureLatency(0, 2, "gapped latency");
    checkOutput("gapped core_in vector", coreInA, basicVec);
    waitIdle(0);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 4; i++) applyStimulus(0, 16'h1111 * 16'(i + 1), 1'b0);
    sA.valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst s_ready forced low", sA.ready, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid reset core_in", coreInA, 0);
    checkOutput("mid reset m_data", mA.data, 0);
    checkOutput("mid reset m_valid", mA.valid, 0);
    checkOutput("mid reset busy", busyA, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready after reset", sA.ready, 1);
    tick();
    sendFrame(0, wrapVec, 0);
    measureLatency(0, 2, "post-reset latency");
    checkOutput("post-reset m_data 0 wraps", mA.data, 16'h0001);
    @(negedge clk);
    checkOutput("post-reset m_data 1", mA.data, 16'h7FFF);
    waitIdle(0);

    $display("[TB] latency sweep CORE_LAT=3");
    sendFrame(1, basicVec, 0);
    measureLatency(1, 4, "first m_valid latency CORE_LAT=3");
    checkOutput("lat3 m_data 0", mB.data, 16'h0300);
    @(negedge clk);
    checkOutput("lat3 m_data 1", mB.data, 16'h0A00);
    waitIdle(1);

`ifdef VEC_STREAM_LAST_EN
    $display("[TB] framing");
    for (int i = 0; i < 5; i++) applyStimulus(0, basicVec[i*16 +: 16], (i == 4));
    sA.valid = 1'b0;
    @(negedge clk);
    checkOutput("frame_err pulse", errA, 1);
    seenValid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mA.valid) seenValid++;
    end
    checkOutput("frame_err cleared", errA, 0);
    checkOutput("dropped frame m_valid count", seenValid, 0);
    tick();
    sendFrame(0, basicVec, 0);
    measureLatency(0, 2, "framed latency");
    checkOutput("framed m_last 0", mA.last, 0);
    checkOutput("framed m_data 0", mA.data, 16'h0300);
    @(negedge clk);
    checkOutput("framed m_last 1", mA.last, 1);
    checkOutput("framed m_data 1", mA.data, 16'h0A00);
    waitIdle(0);
`endif

    repeat (3) tick();
    checkOutput("model queue drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vec_stream_io.md
# vec_stream_io

Streaming front/back end for the combinational MLP cores (e.g. the 10→32→32→2 classifier). It accepts IN_DIM fixed-point features one per cycle over a valid/ready stream and packs them into the core's `in_vec` bus. It waits CORE_LAT cycles, captures the core's packed `out_vec`, and streams its OUT_DIM elements back out one per cycle. It is the clocked producer/consumer end of the packed-vector interface that the cores expose.

## Interface
- IN_DIM, 10: number of elements in the core input vector.
- OUT_DIM, 2: number of elements in the core output vector.
- WIDTH, 16: element width in bits (signed, two's complement).
- CORE_LAT, 1: cycles between driving `core_in` and sampling `core_out`; legal range 1..15.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  input element valid.
- s_ready  output  1  block accepts an input element.
- s_data  input  WIDTH  input element, signed.
- s_last  input  1  frame marker; used only with VEC_STREAM_LAST_EN.
- core_in  output  IN_DIM*WIDTH  packed vector to the core; element i occupies bits [i*WIDTH +: WIDTH].
- core_out  input  OUT_DIM*WIDTH  packed result from the core, same packing.
- m_valid  output  1  output element valid.
- m_ready  input  1  downstream accepts an output element.
- m_data  output  WIDTH  output element, signed.
- m_last  output  1  high with the final output element (VEC_STREAM_LAST_EN only, else 0).
- busy  output  1  high in COMPUTE and SEND.
- frame_err  output  1  one-cycle pulse on a framing error (VEC_STREAM_LAST_EN only, else 0).

## Operation
- FSM states: LOAD, COMPUTE, SEND. Reset state is LOAD.
- **LOAD**
  - s_ready = 1 (forced 0 while rst is high).
  - Each handshake (s_valid & s_ready) writes s_data into element slot `in_idx`, then increments `in_idx`.
  - The first accepted element goes to slot 0.
  - The handshake on slot IN_DIM-1 clears `in_idx`, loads `lat_cnt` = CORE_LAT-1 and moves to COMPUTE.
- **COMPUTE**
  - s_ready = 0. `core_in` is held stable.
  - When `lat_cnt` = 0: register `core_out` into the output buffer, clear `out_idx`, move to SEND. Otherwise decrement `lat_cnt`.
- **SEND**
  - m_valid = 1; m_data = buffer element `out_idx`.
  - Each handshake (m_valid & m_ready) increments `out_idx`.
  - The handshake on element OUT_DIM-1 returns the FSM to LOAD.
  - m_data must hold while m_valid=1 and m_ready=0.
- `core_in` is a register bank. It holds the last loaded values until overwritten, and slots are overwritten one by one during the next LOAD.
- No arithmetic is performed; data passes bit-exact. Counters are $clog2 of their dimension, minimum 1 bit.
- rst high mid-frame discards all partial input and output state and returns the FSM to LOAD. Input is ready again on the first cycle after rst falls.

## Timing
- Reset values:
  - s_ready, m_valid, m_last, busy, frame_err = 0.
  - m_data = 0, core_in = 0.
  - All indices and counters = 0.
- Input handshake on slot IN_DIM-1 at edge k:
  - busy = 1 from the cycle after edge k.
  - `core_out` is sampled at edge k+CORE_LAT.
  - m_valid is first high in the cycle after edge k+CORE_LAT.
- With back-to-back m_ready, SEND lasts exactly OUT_DIM cycles. s_ready is 1 in the cycle after the final output handshake.
- Minimum frame period: IN_DIM + CORE_LAT + OUT_DIM cycles. Frames do not overlap.

## Configuration
- Macro: `VEC_STREAM_LAST_EN`.
- **Defined:**
  - s_last is checked on every input handshake.
  - s_last=1 on a slot other than IN_DIM-1 pulses frame_err, clears `in_idx` and stays in LOAD; the frame is dropped.
  - s_last=0 on slot IN_DIM-1 pulses frame_err the same way and drops the frame.
  - m_last = 1 while `out_idx` = OUT_DIM-1 in SEND.
- **Undefined:**
  - s_last is ignored.
  - m_last and frame_err are tied 0.

## Structure
- Package `vec_stream_pkg` holds:
  - the state enum `vs_state_e` (LOAD, COMPUTE, SEND);
  - the constant `VS_MAX_LAT` = 15.
- One sub-module is natural: `vec_serializer`. It holds the output buffer and `out_idx`, and carries the m_valid/m_ready/m_last handshake.
- The input packing and FSM stay in the top level.

## Test plan
All scenarios use WIDTH=16, IN_DIM=10, OUT_DIM=2, CORE_LAT=1. The bench uses a combinational core model with out0 = in0 + in1 and out1 = in9.
- **Basic frame:** feed 0x0100..0x0A00 (1.0..10.0 Q8.8) back-to-back with m_ready=1.
  - Expect core_in slot 0 = 0x0100 and slot 9 = 0x0A00.
  - Expect m_data 0x0300 then 0x0A00.
  - Expect the first m_valid exactly 2 cycles after the 10th input handshake.
- **Backpressure:** hold m_ready=0 for 5 cycles in SEND.
  - Expect m_valid=1 and m_data=0x0300 stable throughout.
  - Expect the second element only after m_ready rises.
- **Input gaps:** deassert s_valid every other cycle.
  - Expect an identical packed vector.
  - Expect s_ready=0 throughout COMPUTE/SEND.
- **Reset mid-frame:** assert rst after 4 inputs.
  - Expect s_ready=0 during rst and all outputs at their reset values.
  - Expect a following full frame to produce the correct result.
- **Latency sweep:** set CORE_LAT=3.
  - Expect the first m_valid 4 cycles after the last input handshake.
- **Framing (VEC_STREAM_LAST_EN):** send s_last=1 on input 5.
  - Expect a frame_err pulse and no m_valid.
  - Expect the next correct frame to produce m_last=1 on the second output only.
